instr_prefetch_buf: RTL
=======================

INSTR_PREFETCH_BUF -- requirements
Module: instr_prefetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, giving the first fetch byte address after reset.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port fetch_en_i, input, 1, which enables issuing of new fetches.
REQ-006 SHALL have port branch_i, input, 1, a one-cycle redirect strobe.
REQ-007 SHALL have port branch_addr_i, input, 32, the redirect byte address.
REQ-008 SHALL have ports instr_valid_o (output, 1), instr_rdata_o (output, 32) and instr_addr_o (output, 32), the FIFO head toward the core.
REQ-009 SHALL have port instr_ready_i, input, 1; the core accepts the head when it is high.
REQ-010 SHALL have ports mem_req_o (output, 1) and mem_addr_o (output, 12), a word address equal to fetch_addr[13:2].
REQ-011 SHALL have ports mem_we_o (output, 1), mem_wmask_o (output, 4) and mem_wdata_o (output, 32), all tied to 0.
REQ-012 SHALL have ports mem_rdata_i (input, 32) and mem_rvalid_i (input, 1); rvalid is high exactly one cycle after an accepted req, with data valid in that same cycle.
REQ-013 SHALL have port busy_o, output, 1, high while a fetch is in flight or the FIFO is non-empty.

Function
REQ-014 SHALL implement FSM states IDLE and RUN:
- IDLE->RUN when fetch_en_i=1.
- RUN->IDLE when fetch_en_i=0.
- branch_i does not change state.
REQ-015 SHALL assert mem_req_o in RUN only when count + inflight < DEPTH. count is the FIFO occupancy and inflight is 1 if mem_req_o was high in the previous cycle; a same-cycle pop grants no credit.
REQ-016 SHALL increment fetch_addr by 4 on each cycle mem_req_o=1, wrapping modulo 2^32.
REQ-017 SHALL record the issued address in a 1-deep in-flight register and push {addr, mem_rdata_i} into the FIFO when mem_rvalid_i=1 and the response is not discarded.
REQ-018 SHALL pop the FIFO head when instr_valid_o && instr_ready_i; instr_valid_o = (count != 0).
REQ-019 SHALL support simultaneous push and pop in one cycle, leaving count unchanged.
REQ-020 SHALL ignore pushes when the FIFO is full; this is unreachable by REQ-015, and an assertion flags it.
REQ-021 SHALL, on branch_i=1, do all of the following in that cycle:
- flush the FIFO (count<=0, pointers<=0);
- load fetch_addr <= {branch_addr_i[31:2], 2'b00};
- suppress mem_req_o in that cycle;
- mark any in-flight response as discarded;
- give priority over push and pop in the same cycle.
REQ-022 SHALL, while instr_valid_o=1 and instr_ready_i=0, hold instr_rdata_o and instr_addr_o stable unless branch_i flushes.
REQ-023 SHALL let in-flight responses complete normally after a RUN->IDLE transition (the push still occurs).
REQ-024 SHALL wrap FIFO pointers modulo DEPTH and keep count at $clog2(DEPTH)+1 bits.

Reset
REQ-025 SHALL, when rst_ni=0, asynchronously force: state=IDLE, fetch_addr=BOOT_ADDR, count=0, pointers=0, inflight=0, discard=0.
REQ-026 SHALL drive all outputs to 0 during reset: mem_req_o, instr_valid_o, busy_o, instr_rdata_o, instr_addr_o.
REQ-027 SHALL treat reset mid-operation as discarding all buffered and in-flight data; the first mem_req_o after release has mem_addr_o=BOOT_ADDR[13:2].

Verification
REQ-028 SHALL pass this streaming case:
- stimulus: reset release, fetch_en_i=1, instr_ready_i=1, memory returns data=addr;
- response: mem_req_o high every cycle with mem_addr_o 0,1,2,…; instr_addr_o 0x0,0x4,0x8 on consecutive cycles starting 2 cycles after the first req.
REQ-029 SHALL pass this backpressure case:
- stimulus: instr_ready_i=0, DEPTH=4;
- response: exactly 4 reqs issued, then mem_req_o=0, count=4, head=0x0 held stable;
- then instr_ready_i=1 for one cycle gives exactly one additional req.
REQ-030 SHALL pass this branch case:
- stimulus: branch_i=1, branch_addr_i=0x0000_0103 while a fetch is in flight and the FIFO holds 2 entries;
- response: instr_valid_o=0 next cycle, in-flight response dropped, next mem_addr_o=0x040, first delivered instr_addr_o=0x100.
REQ-031 SHALL pass this simultaneous-event case:
- stimulus: push and pop in the same cycle with count=2;
- response: count stays 2 and data order is preserved.
REQ-032 SHALL pass this wrap case:
- stimulus: branch to 0xFFFF_FFFC;
- response: delivered addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-033 SHALL pass this reset case:
- stimulus: rst_ni pulsed low mid-stream;
- response: outputs go 0 immediately without waiting for a clock edge; after release the first req is at BOOT_ADDR.

Source files
------------

// File: rtl/instr_prefetch_buf.sv
// rtl/instr_prefetch_buf.sv - instruction prefetch buffer: sequential fetcher feeding a small FIFO toward the core
module instr_prefetch_buf #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i,
    output logic        mem_req_o,
    output logic [11:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    output logic        busy_o
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    logic [0:0]    state_q;
    logic [31:0]   fetch_addr_q;
    logic [PW:0]   count_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          inflight_q;
    logic [31:0]   inflight_addr_q;
    logic          discard_q;

    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];

    logic [PW+1:0] credit;
    logic          fifo_full;
    logic          rsp_push;
    logic          push;
    logic          pop;

    // Outstanding response counts against capacity so a full FIFO can never be overrun.
    assign credit    = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    assign fifo_full = (count_q == DEPTH_C);

    assign mem_req_o  = (state_q == STATE_RUN) && !branch_i && (credit < DEPTH_W);
    assign mem_addr_o = fetch_addr_q[13:2];
    assign mem_we_o    = 1'b0;
    assign mem_wmask_o = 4'b0000;
    assign mem_wdata_o = 32'h0000_0000;

    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = instr_valid_o ? buf_data[rd_ptr_q] : 32'h0000_0000;
    assign instr_addr_o  = instr_valid_o ? buf_addr[rd_ptr_q] : 32'h0000_0000;
    assign busy_o        = inflight_q || instr_valid_o;

    assign rsp_push = mem_rvalid_i && inflight_q && !discard_q && !branch_i;
    assign push     = rsp_push && !fifo_full;
    assign pop      = instr_valid_o && instr_ready_i && !branch_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STATE_IDLE;
        end else if (state_q == STATE_IDLE && fetch_en_i) begin
            state_q <= STATE_RUN;
        end else if (state_q == STATE_RUN && !fetch_en_i) begin
            state_q <= STATE_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q    <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 32'h0000_0000;
            discard_q       <= 1'b0;
        end else begin
            inflight_q <= mem_req_o;
            if (mem_req_o) begin
                inflight_addr_q <= fetch_addr_q;
            end
            if (branch_i) begin
                fetch_addr_q <= branch_addr_i & 32'hFFFF_FFFC;
            end else if (mem_req_o) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
            end
            // A response still owed after a redirect belongs to the old stream.
            if (branch_i) begin
                discard_q <= inflight_q && !mem_rvalid_i;
            end else if (mem_rvalid_i) begin
                discard_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (branch_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= inflight_addr_q;
            buf_data[wr_ptr_q] <= mem_rdata_i;
        end
    end

    overflow_never: assert property (@(posedge clk_i) disable iff (!rst_ni) !(rsp_push && fifo_full));

endmodule
